// File: rtl/cic_comp_fir_if.sv
// Sample bus between the CIC decimator, the compensation FIR and the demodulator.
// The master drives the CIC sample and its sample clock; the slave returns the
// filtered sample, its valid strobe and status flags.
interface cic_comp_fir_if;
  logic signed [7:0] d_in;
  logic              d_clk_in;
  logic signed [7:0] d_out;
  logic              d_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output d_in, d_clk_in,
    input  d_out, d_valid, busy, overrun
  );

  modport slave (
    input  d_in, d_clk_in,
    output d_out, d_valid, busy, overrun
  );
endinterface

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR with decimation, single shared MAC.
// Each rising edge of d_clk_in captures one CIC sample into a circular delay
// line. Every DECIM-th accepted sample starts a TAPS-cycle MAC pass, followed
// by one ROUND cycle and one OUT cycle that drives d_out / d_valid.
// Macro CIC_COMP_ROUND_EN: when defined, ROUND adds 0.5 LSB before the >>>9
// (round-half-up); when undefined, ROUND truncates toward -inf. The latency
// is identical in both builds.
module cic_comp_fir #(
  parameter int TAPS   = 16,
  parameter int DECIM  = 2,
  parameter int COEF_W = 10,
  parameter int ACC_W  = 24
) (
  input  logic           clk,
  input  logic           rst,
  cic_comp_fir_if.slave  bus
);

  localparam int PTR_W  = (TAPS > 1)  ? $clog2(TAPS)  : 1;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PROD_W = 8 + COEF_W;

`ifdef CIC_COMP_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(256);
`else
  localparam logic signed [ACC_W-1:0] RND_BIAS = '0;
`endif

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  // Symmetric compensation kernel, sum 512 (unity in Q1.9). Other tap counts
  // fall back to a plain two-tap centre average so the block stays usable.
  function automatic int coef_val(input int k);
    int m;
    if (TAPS == 16) begin
      m = (k < 8) ? k : 15 - k;
      case (m)
        0:       return -4;
        1:       return -6;
        2:       return 0;
        3:       return 14;
        4:       return 20;
        5:       return 0;
        6:       return -40;
        default: return 272;
      endcase
    end else begin
      return ((k == TAPS/2 - 1) || (k == TAPS/2)) ? 256 : 0;
    end
  endfunction

  logic signed [COEF_W-1:0] coef_rom [TAPS];

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
      assign coef_rom[gi] = COEF_W'(coef_val(gi));
    end
  endgenerate

  state_t                  state_q;
  logic                    prev_q;
  logic signed [7:0]       line_q [TAPS];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        k_q;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] rnd_q;
  logic signed [7:0]       d_out_q, sat_d;
  logic                    d_valid_q, busy_q, overrun_q;
  logic                    capture, wr_en;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign capture = bus.d_clk_in & ~prev_q;
  assign wr_en   = capture && (state_q == IDLE);

  // Pointer/phase successors, product of the current tap and the saturator.
  always_comb begin
    wr_ptr_d = (wr_ptr_q == PTR_W'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = (rd_ptr_q == '0) ? PTR_W'(TAPS - 1) : rd_ptr_q - 1'b1;
    phase_d  = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    prod     = line_q[rd_ptr_q] * coef_rom[k_q];
    prod_ext = $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    if (rnd_q > SAT_HI)      sat_d = 8'sd127;
    else if (rnd_q < SAT_LO) sat_d = -8'sd128;
    else                     sat_d = rnd_q[7:0];
  end

  // Circular delay line: cleared on reset, one write per accepted capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) line_q[i] <= '0;
    end else if (wr_en) begin
      line_q[wr_ptr_q] <= bus.d_in;
    end
  end

  // Edge detect, capture bookkeeping and the MAC/ROUND/OUT sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      k_q       <= '0;
      phase_q   <= '0;
      acc_q     <= '0;
      rnd_q     <= '0;
      d_out_q   <= '0;
      d_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      prev_q    <= bus.d_clk_in;
      d_valid_q <= 1'b0;
      // A sample arriving mid-computation is lost; remember that it happened.
      if (capture && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (capture) begin
            wr_ptr_q <= wr_ptr_d;
            phase_q  <= phase_d;
            // Newest sample sits at the slot being written now.
            rd_ptr_q <= wr_ptr_q;
            k_q      <= '0;
            acc_q    <= '0;
            if (phase_q == PH_W'(DECIM - 1)) begin
              state_q <= MAC;
              busy_q  <= 1'b1;
            end
          end
        end
        MAC: begin
          acc_q    <= acc_q + prod_ext;
          rd_ptr_q <= rd_ptr_d;
          k_q      <= k_q + 1'b1;
          if (k_q == PTR_W'(TAPS - 1)) state_q <= ROUND;
        end
        ROUND: begin
          rnd_q   <= (acc_q + RND_BIAS) >>> 9;
          state_q <= OUT;
        end
        default: begin
          d_out_q   <= sat_d;
          d_valid_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.d_out   = d_out_q;
  assign bus.d_valid = d_valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir. A sample-history model computes each
// expected output directly from the coefficient table and predicts the cycle
// on which d_valid must appear; a per-cycle monitor checks d_valid/d_out.
module tb_cic_comp_fir;

  localparam int TAPS  = 16;
  localparam int DECIM = 2;
  localparam int LAT   = TAPS + 2;

`ifdef CIC_COMP_ROUND_EN
  localparam int BIAS = 256;
`else
  localparam int BIAS = 0;
`endif

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  cic_comp_fir_if bus ();

  cic_comp_fir #(.TAPS(TAPS), .DECIM(DECIM), .COEF_W(10), .ACC_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int   coef [TAPS] = '{-4, -6, 0, 14, 20, 0, -40, 272, 272, -40, 0, 20, 14, 0, -6, -4};
  int   hist [$];
  exp_t exp_q [$];
  int   obs [$];
  int   busy_until = -1;
  int   exp_ovr = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int floor512(input int a);
    if (a >= 0) return a / 512;
    return -((-a + 511) / 512);
  endfunction

  // Reference: dot product of the coefficients with the most recent samples.
  task automatic model_capture(input int s, input int edge_no);
    int acc, idx, val;
    if (edge_no <= busy_until) begin
      exp_ovr = 1;
    end else begin
      hist.push_back(s);
      if (hist.size() % DECIM == 0) begin
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
          idx = hist.size() - 1 - k;
          if (idx >= 0) acc += coef[k] * hist[idx];
        end
        val = floor512(acc + BIAS);
        if (val > 127)  val = 127;
        if (val < -128) val = -128;
        exp_q.push_back('{val, edge_no + LAT});
        busy_until = edge_no + LAT;
      end
    end
  endtask

  // One transaction line per d_valid; timing and value checked against model.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("valid_at_due", int'(bus.d_valid), 1);
      check("d_out", int'(bus.d_out), exp_q[0].val);
      $display("cycle %0d: d_out=%0d expected=%0d", cyc, bus.d_out, exp_q[0].val);
      void'(exp_q.pop_front());
    end else begin
      check("idle_valid", int'(bus.d_valid), 0);
    end
    if (bus.d_valid) obs.push_back(int'(bus.d_out));
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    bus.d_clk_in = 1'b0;
    hist.delete();
    exp_q.delete();
    obs.delete();
    busy_until = -1;
    exp_ovr = 0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    check("rst_d_out", int'(bus.d_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overrun", int'(bus.overrun), 0);
  endtask

  // Rising edge of d_clk_in, high one cycle, then low; next send gap cycles later.
  task automatic send(input int s, input int gap);
    @(negedge clk);
    bus.d_in = 8'(s);
    bus.d_clk_in = 1'b1;
    model_capture(s, cyc + 1);
    @(negedge clk);
    bus.d_clk_in = 1'b0;
    repeat (gap - 2) @(negedge clk);
    check("overrun", int'(bus.overrun), exp_ovr);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
  endtask

  logic signed [7:0] rs;
  int neg_last;

  initial begin
    bus.d_in = '0;
    bus.d_clk_in = 1'b0;

    // Constant input settles to the input value (unity DC gain).
    do_reset(2);
    for (int i = 0; i < 40; i++) send(10, 32);
    drain();
    check("const10_final", int'(bus.d_out), 10);

    // Impulse response: odd taps appear in successive outputs.
    do_reset(2);
    send(100, 32);
    for (int i = 0; i < 19; i++) send(0, 32);
    drain();
    check("impulse_count", obs.size(), 10);
`ifdef CIC_COMP_ROUND_EN
    check("impulse_0", obs[0], -1);
    check("impulse_1", obs[1], 3);
    check("impulse_3", obs[3], 53);
`else
    check("impulse_0", obs[0], -2);
    check("impulse_1", obs[1], 2);
    check("impulse_3", obs[3], 53);
`endif
    check("impulse_2", obs[2], 0);
    check("impulse_9", obs[9], 0);

    // Positive and negative saturation.
    do_reset(2);
    send(0, 32); send(127, 32); send(127, 32);
    for (int i = 0; i < 7; i++) send(0, 32);
    drain();
    check("sat_pos", obs[4], 127);
    do_reset(2);
    send(0, 32); send(-128, 32); send(-128, 32);
    for (int i = 0; i < 7; i++) send(0, 32);
    drain();
    neg_last = obs[4];
    check("sat_neg", neg_last, -128);

    // Overrun: captures faster than the filter can service.
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      rs = 8'($urandom_range(0, 255));
      send(int'(rs), 10);
    end
    drain();
    check("overrun_sticky", int'(bus.overrun), 1);

    // Reset in the middle of a MAC pass discards the computation.
    do_reset(2);
    send(5, 32);
    send(7, 6);
    do_reset(1);
    repeat (25) @(negedge clk);
    check("abort_d_out", int'(bus.d_out), 0);
    check("abort_busy", int'(bus.busy), 0);
    for (int i = 0; i < 20; i++) send(20, 32);
    drain();
    check("const20_final", int'(bus.d_out), 20);

    // Long high time on d_clk_in gives a single capture.
    do_reset(2);
    @(negedge clk);
    bus.d_in = 8'sd50;
    bus.d_clk_in = 1'b1;
    model_capture(50, cyc + 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.d_in = 8'($urandom_range(0, 255));
    end
    bus.d_clk_in = 1'b0;
    check("hold_busy", int'(bus.busy), 0);
    for (int i = 0; i < 6; i++) send(0, 32);
    drain();
    check("hold_outputs", obs.size(), 3);

    // Randomized samples and spacing, mostly legal with occasional overruns.
    do_reset(2);
    for (int i = 0; i < 80; i++) begin
      rs = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) send(int'(rs), $urandom_range(4, TAPS + 2));
      else                           send(int'(rs), $urandom_range(TAPS + 3, 40));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
